// File: rtl/divider_pkg.sv
// Shared definitions for the rv32im divider: op encodings and small helpers.
package divider_pkg;

    // Operation encodings used by the control-unit decode of funct3 100..111.
    localparam int DIV_OP_WIDTH = 2;
    localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIV  = 2'd0;
    localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIVU = 2'd1;
    localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REM  = 2'd2;
    localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REMU = 2'd3;

    localparam int DATA_W = 32;

    // Two's-complement negation of a 32-bit word.
    function automatic logic [DATA_W-1:0] neg32(input logic [DATA_W-1:0] v);
        return (~v) + 32'd1;
    endfunction

    // Magnitude of a word that is negative only when treated as signed.
    function automatic logic [DATA_W-1:0] mag32(input logic [DATA_W-1:0] v,
                                                input logic               is_neg);
        return is_neg ? neg32(v) : v;
    endfunction

endpackage

// File: rtl/divider.sv
// Multicycle restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Fixed latency: accept, 32 CALC steps, one READY cycle that writes result.
module divider
    import divider_pkg::*;
(
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [DATA_W-1:0]       dividend,
    input  logic [DATA_W-1:0]       divisor,
    input  logic [DIV_OP_WIDTH-1:0] DIVop,
    input  logic                    valid,
    output logic [DATA_W-1:0]       result,
    output logic                    ready
);

    // One-hot state encoding; bit positions are private to this module.
    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        CALC  = 3'b010,
        READY = 3'b100
    } state_t;

    state_t            state_q;
    logic              ready_q;
    logic [DATA_W-1:0] result_q;
    logic [4:0]        cnt_q;

    logic              is_signed_q;
    logic              want_rem_q;
    logic              sign_dvd_q;
    logic              sign_dvs_q;
    logic              dvs_zero_q;
    logic [DATA_W-1:0] dvs_q;      // |divisor|
    logic [DATA_W-1:0] quo_q;      // dividend magnitude shifting out, quotient shifting in
    logic [DATA_W:0]   rem_q;      // 33-bit partial remainder

    // Accept-time decode of the incoming request.
    logic              acc_signed_d;
    logic              acc_sdvd_d;
    logic              acc_sdvs_d;

    // Restoring step datapath.
    logic [DATA_W:0]   rem_shift_d;
    logic [DATA_W+1:0] trial_d;
    logic [DATA_W-1:0] quo_fix_d;
    logic [DATA_W-1:0] rem_fix_d;

    assign result = result_q;
    assign ready  = ready_q;

    // Decode the request and compute one restoring trial subtraction.
    always_comb begin
        acc_signed_d = (DIVop == DIV_OP_DIV) || (DIVop == DIV_OP_REM);
        acc_sdvd_d   = acc_signed_d && dividend[DATA_W-1];
        acc_sdvs_d   = acc_signed_d && divisor[DATA_W-1];

        rem_shift_d  = {rem_q[DATA_W-1:0], quo_q[DATA_W-1]};
        trial_d      = {rem_q, quo_q[DATA_W-1]} - {2'b00, dvs_q};

        quo_fix_d    = (is_signed_q && (sign_dvd_q ^ sign_dvs_q) && !dvs_zero_q)
                       ? neg32(quo_q) : quo_q;
        rem_fix_d    = (is_signed_q && sign_dvd_q)
                       ? neg32(rem_q[DATA_W-1:0]) : rem_q[DATA_W-1:0];
    end

    // Control FSM with registered ready/result and the iterative datapath.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (valid && !ready_q) begin
                        is_signed_q <= acc_signed_d;
                        want_rem_q  <= (DIVop == DIV_OP_REM) || (DIVop == DIV_OP_REMU);
                        sign_dvd_q  <= acc_sdvd_d;
                        sign_dvs_q  <= acc_sdvs_d;
                        dvs_zero_q  <= (divisor == '0);
                        quo_q       <= mag32(dividend, acc_sdvd_d);
                        dvs_q       <= mag32(divisor, acc_sdvs_d);
                        rem_q       <= '0;
                        cnt_q       <= '0;
                        state_q     <= CALC;
                    end
                end
                CALC: begin
                    if (!trial_d[DATA_W+1]) begin
                        rem_q <= trial_d[DATA_W:0];
                        quo_q <= {quo_q[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_q <= rem_shift_d;
                        quo_q <= {quo_q[DATA_W-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= READY;
                    end
                end
                READY: begin
                    result_q <= want_rem_q ? rem_fix_d : quo_fix_d;
                    ready_q  <= 1'b1;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for the restoring divider: driver pushes expected results,
// a negedge monitor pops and compares whenever ready is seen.
module tb_divider;
    import divider_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [1:0]  DIVop = '0;
    logic        valid = 1'b0;
    logic [31:0] result;
    logic        ready;

    divider dut (
        .clk      (clk),
        .resetn   (resetn),
        .dividend (dividend),
        .divisor  (divisor),
        .DIVop    (DIVop),
        .valid    (valid),
        .result   (result),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] exp;
        int          acc;
        string       name;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    logic prev_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: compares every ready pulse against the head of the scoreboard.
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            sb_t e;
            check("single_cycle_ready", {31'd0, prev_ready}, 32'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check({e.name, "_result"}, result, e.exp);
                check({e.name, "_latency"}, cyc - e.acc, 32'd33);
            end
        end
        prev_ready = ready;
    end

    // Wait (bounded) for the next ready pulse, sampled on negedge.
    task automatic wait_ready(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ready !== 1'b1 && n < 100);
        if (ready !== 1'b1) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Issue one request; optionally scramble inputs after accept and hold valid past ready.
    task automatic do_op(input string name, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit garbage, input bit hold);
        sb_t e;
        @(negedge clk);
        DIVop = op; dividend = a; divisor = b; valid = 1'b1;
        @(posedge clk);
        #1;
        e.exp = exp; e.acc = cyc; e.name = name;
        sb_q.push_back(e);
        if (garbage) begin
            dividend = $urandom; divisor = $urandom; DIVop = ~op;
        end
        wait_ready(name);
        if (hold) begin
            e.exp = exp; e.acc = cyc + 2; e.name = {name, "_again"};
            sb_q.push_back(e);
            @(negedge clk);
            @(negedge clk);
            valid = 1'b0;
            wait_ready({name, "_again"});
        end else begin
            valid = 1'b0;
        end
    endtask

    initial begin
        int saw_ready;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_result", result, 32'd0);
        resetn = 1'b1;

        do_op("divu_100_7",    DIV_OP_DIVU, 32'd100,        32'd7,          32'd14,         0, 0);
        do_op("remu_100_7",    DIV_OP_REMU, 32'd100,        32'd7,          32'd2,          0, 0);
        do_op("div_m7_2",      DIV_OP_DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   0, 0);
        do_op("rem_m7_2",      DIV_OP_REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   0, 0);
        do_op("div_7_m2",      DIV_OP_DIV,  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   0, 0);
        do_op("rem_7_m2",      DIV_OP_REM,  32'd7,          32'hFFFFFFFE,   32'd1,          0, 0);
        do_op("div_5_0",       DIV_OP_DIV,  32'd5,          32'd0,          32'hFFFFFFFF,   0, 0);
        do_op("divu_5_0",      DIV_OP_DIVU, 32'd5,          32'd0,          32'hFFFFFFFF,   0, 0);
        do_op("rem_m5_0",      DIV_OP_REM,  32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   0, 0);
        do_op("remu_dead_0",   DIV_OP_REMU, 32'hDEADBEEF,   32'd0,          32'hDEADBEEF,   0, 0);
        do_op("div_ovf",       DIV_OP_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   0, 0);
        do_op("rem_ovf",       DIV_OP_REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          0, 0);
        do_op("divu_max_1",    DIV_OP_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   0, 0);
        do_op("divu_garbage",  DIV_OP_DIVU, 32'd1000,       32'd10,         32'd100,        1, 0);
        do_op("remu_hold",     DIV_OP_REMU, 32'd100,        32'd7,          32'd2,          0, 1);

        // Abort an operation with a one-cycle reset at CALC step 10.
        @(negedge clk);
        DIVop = DIV_OP_DIVU; dividend = 32'd1000; divisor = 32'd3; valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        saw_ready = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready === 1'b1) saw_ready++;
        end
        check("abort_no_ready", saw_ready, 32'd0);

        do_op("divu_after_abort", DIV_OP_DIVU, 32'h10, 32'h3, 32'd5, 0, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d cycles required < 20000", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Multicycle iterative divider for the rv32im datapath; it is the inverse counterpart of the multiplier.
- Executes DIV, DIVU, REM and REMU with RISC-V semantics, including the divide-by-zero and signed-overflow cases.
- Uses a restoring algorithm at one quotient bit per cycle.
- Sits beside the multiplier under the main control FSM and shares its valid/ready handshake style.

Parameters:
- none. Op encodings come from the shared defines header.

Ports:
- clk  input  1  system clock.
- resetn  input  1  reset. One clock; synchronous and active-low.
- dividend  input  32  rs1 operand.
- divisor  input  32  rs2 operand.
- DIVop  input  `DIV_OP_WIDTH  operation select: DIV, DIVU, REM or REMU.
- valid  input  1  request. Held high by the control FSM until ready.
- result  output  32  quotient or remainder, per DIVop captured at accept.
- ready  output  1  one-cycle done pulse. Registered.

Behaviour:
- Reset: while resetn is low at a clk edge, the block sets:
  - state = IDLE;
  - ready = 0;
  - result = 0;
  - step counter = 0.
- Reset mid-operation aborts the operation: no ready pulse, partial state discarded, next request starts clean.
- FSM is one-hot, with states IDLE, CALC and READY.
- IDLE:
  - ready <= 0.
  - Accept when valid && !ready. On accept, latch:
    - op;
    - is_signed (DIV or REM);
    - want_rem (REM or REMU);
    - dividend sign and divisor sign, qualified by is_signed;
    - divisor_zero;
    - |dividend| and |divisor| as two's-complement magnitudes when signed and negative.
  - On accept, also clear the remainder accumulator (33 bits) and the counter. Go to CALC.
  - dividend, divisor and DIVop are don't-care after the accept edge.
- CALC: 32 iterations, MSB-first restoring step.
  - Shift {rem, quo} left by one, bringing in the next dividend magnitude bit.
  - trial = rem_shifted - |divisor|.
  - If trial is non-negative: rem = trial and the new quotient bit = 1. Otherwise rem is unchanged and the bit = 0.
  - The counter increments each step. When the counter is 31, go to READY.
- READY: perform the sign fix-up, write result, set ready <= 1, go to IDLE.
  - Quotient is negated when is_signed && (sign_dividend ^ sign_divisor) && !divisor_zero.
  - Remainder is negated when is_signed && sign_dividend.
  - result = want_rem ? remainder : quotient.
- Latency is fixed for every operand value, so the bench checks exact cycles:
  - accept edge E;
  - CALC on edges E+1..E+32;
  - ready high for exactly the one cycle after edge E+33.
- Divide by zero, with no special timing:
  - quotient = 0xFFFFFFFF for both DIV and DIVU;
  - remainder = the original dividend (sign restored).
  - The restoring core yields these naturally; the fix-up rules above must not disturb them.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. This falls out of 32-bit magnitude arithmetic with no special case.
- Handshake:
  - After a ready pulse, the IDLE guard (!ready) blocks re-accept on the same edge.
  - If valid is still high one cycle later, a new operation starts. The requester must drop valid on seeing ready.
- result holds its value until the next READY write and is stable while ready is high.

Decomposition:
- riscv_defines.vh gains:
  - `DIV_OP_WIDTH (2);
  - `DIV_OP_DIV (0), `DIV_OP_DIVU (1), `DIV_OP_REM (2), `DIV_OP_REMU (3).
- The control-unit decode for funct3 100..111 maps onto these.
- State bit indices are local to the module.
- No sub-module: the single restoring step is inline.
- A separate unsigned core is not warranted at this size.

Test Plan:
- DIVU 100/7 -> 14; REMU 100/7 -> 2. ready pulses exactly one cycle, 33 edges after accept.
- DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIV 7/-2 -> -3; REM 7/-2 -> 1.
- Divide by zero:
  - DIV 5/0 and DIVU 5/0 -> 0xFFFFFFFF;
  - REM -5/0 -> 0xFFFFFFFB;
  - REMU 0xDEADBEEF/0 -> 0xDEADBEEF.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0. DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
- Operands and DIVop changed to garbage one cycle after accept -> result is still that of the latched request. Valid held two cycles past ready -> second operation starts, ready is not asserted twice back-to-back.
- resetn low for one cycle at CALC step 10 -> no ready pulse. A following DIVU 0x10/0x3 -> 5, with normal latency.
